// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   OP_*    : operation encodings presented on the Op port
//   state_e : control FSM states
//   CNT_W   : iteration counter width for the default 32-bit unit
//   cnt_width() : counter width for an arbitrary operand width
package mdu_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // One extra bit so the counter can reach WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = $clog2(MDU_WIDTH) + 1;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation.
//   in_i  : N-bit value
//   neg_i : 1 = output -in_i, 0 = pass in_i through
//   out_o : result (wraps modulo 2^N, so -MIN == MIN)
module mdu_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + N'(1)) : in_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO.
// Multiply is shift-add, divide is restoring shift-subtract; both run on
// operand magnitudes and fix up signs in a final FIX cycle.
//   clk, rst          : clock, synchronous active-high reset
//   Start, Op         : launch MULTU/MULT/DIVU/DIV (accepted only in IDLE)
//   OpA, OpB          : operands, captured at Start
//   WriteHI/LO, WriteData : MTHI/MTLO, honoured only while idle
//   Busy              : operation in flight (RUN or FIX)
//   Done              : one-cycle pulse after HI/LO take the result
//   HI, LO            : product high/low, or remainder/quotient
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             WriteHI,
  input  logic             WriteLO,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // |OpA|
  logic [WIDTH-1:0]   b_q, b_d;          // |OpB|
  logic [WIDTH-1:0]   opa_raw_q, opa_raw_d;
  logic               neg_p_q, neg_p_d;  // negate product
  logic               neg_qt_q, neg_qt_d; // negate quotient
  logic               neg_r_q, neg_r_d;  // negate remainder
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  // ---------------- operand magnitudes at Start ----------------
  logic             op_signed, sign_diff;
  logic [WIDTH-1:0] opa_mag, opb_mag;

  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign sign_diff = OpA[WIDTH-1] ^ OpB[WIDTH-1];

  mdu_negate #(.N(WIDTH)) u_neg_a (
    .in_i (OpA),
    .neg_i(op_signed & OpA[WIDTH-1]),
    .out_o(opa_mag)
  );

  mdu_negate #(.N(WIDTH)) u_neg_b (
    .in_i (OpB),
    .neg_i(op_signed & OpB[WIDTH-1]),
    .out_o(opb_mag)
  );

  // ---------------- iteration datapath ----------------
  logic             is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign is_mul = (op_q == OP_MULTU) || (op_q == OP_MULT);

  // Multiply: acc = {partial, multiplier}. Add multiplicand on LSB, then
  // shift right keeping the carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}. Shift left one bit, try
  // subtracting the divisor; the borrow bit (MSB) says whether to restore.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  // ---------------- sign correction ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mdu_negate #(.N(2*WIDTH)) u_neg_p (
    .in_i (acc_q),
    .neg_i(neg_p_q),
    .out_o(prod_fix)
  );

  mdu_negate #(.N(WIDTH)) u_neg_q (
    .in_i (acc_q[WIDTH-1:0]),
    .neg_i(neg_qt_q),
    .out_o(quo_fix)
  );

  mdu_negate #(.N(WIDTH)) u_neg_r (
    .in_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i(neg_r_q),
    .out_o(rem_fix)
  );

  // ---------------- FSM / next state ----------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opa_raw_d = opa_raw_q;
    neg_p_d   = neg_p_q;
    neg_qt_d  = neg_qt_q;
    neg_r_d   = neg_r_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (WriteHI) hi_d = WriteData;
        if (WriteLO) lo_d = WriteData;
        if (Start) begin
          op_d      = Op;
          a_d       = opa_mag;
          b_d       = opb_mag;
          opa_raw_d = OpA;
          neg_p_d   = (Op == OP_MULT) && sign_diff;
          neg_qt_d  = (Op == OP_DIV) && sign_diff;
          neg_r_d   = (Op == OP_DIV) && OpA[WIDTH-1];
          // Upper half cleared; lower half seeds the shifting operand.
          acc_d     = {{WIDTH{1'b0}},
                       ((Op == OP_MULTU) || (Op == OP_MULT)) ? opb_mag : opa_mag};
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = is_mul ? mul_next : div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_mul) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          // Divide by zero: quotient all ones, remainder is the raw dividend.
          hi_d = opa_raw_q;
          lo_d = '1;
        end else begin
          // MIN / -1 falls out naturally: |MIN| quotient negates back to MIN.
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      opa_raw_q <= '0;
      neg_p_q   <= 1'b0;
      neg_qt_q  <= 1'b0;
      neg_r_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opa_raw_q <= opa_raw_d;
      neg_p_q   <= neg_p_d;
      neg_qt_q  <= neg_qt_d;
      neg_r_q   <= neg_r_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the register file and takes its two read-data outputs as operands for MULT, MULTU, DIV and DIVU. It produces HI/LO for MFHI/MFLO and raises Busy so the control path can stall.
- Radix-2 algorithm: one result bit per cycle.
- Shift-add for multiply, restoring shift-subtract for divide.

Parameters:
WIDTH, 32, operand width and iteration count (HI and LO are each WIDTH bits).

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; synchronous, active-high
Start  input  1  request an operation; sampled only in IDLE
Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
OpA  input  WIDTH  multiplicand / dividend (register file read port 1)
OpB  input  WIDTH  multiplier / divisor (register file read port 2)
WriteHI  input  1  MTHI write strobe
WriteLO  input  1  MTLO write strobe
WriteData  input  WIDTH  MTHI/MTLO data
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse; HI/LO hold the new result
HI  output  WIDTH  HI register (product upper half / remainder)
LO  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, Busy=0, Done=0, HI=0, LO=0, iteration counter=0. Reset aborts any operation in flight and no Done is produced.
- States: IDLE, RUN, FIX.
- IDLE with Start=1 at edge k:
  - Latch Op, |OpA|, |OpB| (magnitudes only for signed ops) and the result signs.
  - Clear the accumulator and counter; next state RUN; Busy=1 after edge k.
- RUN: one iteration per edge; counter increments.
  - After WIDTH iterations (edge k+WIDTH) go to FIX.
- FIX (edge k+WIDTH+1):
  - Apply sign correction and write HI and LO together.
  - Done=1 and Busy=0 for the following cycle; next state IDLE.
  - Start-to-Done latency is exactly WIDTH+1 edges (33 for WIDTH=32).
- Done is asserted for exactly one cycle; it is 0 in every other cycle.
- HI/LO hold their previous values throughout RUN. They change only in FIX, on MTHI/MTLO, or on reset.
- Start while Busy=1 is ignored (not queued).
- Multiply: 2*WIDTH-bit unsigned product of magnitudes.
  - MULT negates the full 2*WIDTH product when exactly one operand is negative.
  - HI = upper half, LO = lower half.
- Divide sign rules (truncating toward zero):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero (either form): LO=all ones, HI=OpA as latched (unmodified original value). Full WIDTH+1 latency still applies.
- DIV overflow (OpA=most-negative, OpB=-1): LO=OpA (0x80000000), HI=0.
- MTHI/MTLO: WriteHI/WriteLO update the register at the edge, only when Busy=0 and state≠FIX; otherwise ignored.
  - WriteHI and WriteLO in the same cycle write both registers with WriteData.
  - Start together with a write in IDLE: the write takes effect; the operation proceeds and its FIX overwrites both registers.
- Operands are captured at Start. Changes on OpA/OpB during RUN have no effect.

Decomposition:
- Shared package mdu_pkg:
  - Op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
  - State encoding (S_IDLE, S_RUN, S_FIX).
  - Counter width constant, $clog2(WIDTH)+1.
- Sub-module mdu_negate: combinational conditional two's-complement of an N-bit value, parameterised width. Instantiated for operand magnitudes, 2*WIDTH product correction, quotient and remainder.
- FSM and datapath stay in mult_div_unit.

Test Plan:
- Reset, then MULTU OpA=0xFFFFFFFF OpB=0xFFFFFFFF -> Busy high for 33 cycles, Done pulse 33 edges after Start, HI=0xFFFFFFFE LO=0x00000001.
- MULT OpA=0xFFFFFFFD (-3) OpB=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1; then DIV OpA=0xFFFFFFF9 (-7) OpB=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
- DIVU OpA=100 OpB=0 -> LO=0xFFFFFFFF HI=0x00000064; DIV OpA=0x80000000 OpB=0xFFFFFFFF -> LO=0x80000000 HI=0x00000000.
- During a DIVU 1000/7: pulse Start with new operands and WriteHI=1 WriteData=0xDEADBEEF mid-RUN -> both ignored, exactly one Done, LO=142 HI=6.
- Start MULTU 0x1234*0x10, assert rst at iteration 10 -> next cycle Busy=0 HI=LO=0; no Done pulse in the following 40 cycles.
- IDLE: WriteLO=1 WriteData=0xCAFEF00D -> LO=0xCAFEF00D, HI unchanged, Done stays 0.
